// File: rtl/tank_shot_engine.sv
// Fire-button front end and shell animator for the tank game: debounces the button,
// charges shot power while held, then flies the shell across the 8-column field.
module tank_shot_engine #(
    parameter int TICK_DIV   = 5_000_000,
    parameter int DEB_CYCLES = 100_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       fire_btn,
    input  logic       turn,
    input  logic [3:0] tank1_location,
    input  logic [3:0] tank2_location,
    output logic       fire,
    output logic       hit,
    output logic [7:0] shell_col,
    output logic [2:0] power,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        FLY
    } state_t;

    state_t state;

    logic          sync1;
    logic          sync2;
    logic          btn_d;
    logic          btn_prev;
    logic [DW-1:0] deb_cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            btn_d    <= 1'b0;
            btn_prev <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= fire_btn;
            sync2    <= sync1;
            btn_prev <= btn_d;
            if (sync2 == btn_d) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_d   <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    logic btn_rise;
    logic btn_fall;

    assign btn_rise = btn_d & ~btn_prev;
    assign btn_fall = ~btn_d & btn_prev;

    logic       t1_valid;
    logic       t2_valid;
    logic [2:0] t1_col;
    logic [2:0] t2_col;

    // Highest set bit wins; tank1 occupies columns 5..7, tank2 columns 0..2.
    always_comb begin
        t1_valid = 1'b1;
        t1_col   = 3'd0;
        if (tank1_location[3])      t1_col = 3'd7;
        else if (tank1_location[2]) t1_col = 3'd6;
        else if (tank1_location[1]) t1_col = 3'd5;
        else                        t1_valid = 1'b0;

        t2_valid = 1'b1;
        t2_col   = 3'd0;
        if (tank2_location[2])      t2_col = 3'd2;
        else if (tank2_location[1]) t2_col = 3'd1;
        else if (tank2_location[0]) t2_col = 3'd0;
        else                        t2_valid = 1'b0;
    end

    logic unused_loc_bits;
    assign unused_loc_bits = tank1_location[0] | tank2_location[3];

    logic       src_valid;
    logic       dst_valid;
    logic [2:0] src_col;
    logic [2:0] dst_col;

    always_comb begin
        src_valid = turn ? t2_valid : t1_valid;
        src_col   = turn ? t2_col   : t1_col;
        dst_valid = turn ? t1_valid : t2_valid;
        dst_col   = turn ? t1_col   : t2_col;
    end

    logic [TW-1:0] tick;
    logic [2:0]    step;
    logic [2:0]    pos;
    logic [2:0]    tgt_col;
    logic          tgt_valid;
    logic          shoot_valid;
    logic          dir_up;
    logic [2:0]    pos_next;
    logic          edge_exit;
    logic          tick_done;

    always_comb begin
        pos_next  = dir_up ? (pos + 3'd1) : (pos - 3'd1);
        edge_exit = dir_up ? (pos == 3'd7) : (pos == 3'd0);
        tick_done = (tick == TICK_LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            fire        <= 1'b0;
            hit         <= 1'b0;
            shell_col   <= '0;
            power       <= '0;
            tick        <= '0;
            step        <= '0;
            pos         <= '0;
            tgt_col     <= '0;
            tgt_valid   <= 1'b0;
            shoot_valid <= 1'b0;
            dir_up      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    fire      <= 1'b0;
                    shell_col <= '0;
                    if (btn_rise) begin
                        state <= CHARGE;
                        fire  <= 1'b1;
                        hit   <= 1'b0;
                        power <= '0;
                        tick  <= '0;
                    end
                end

                CHARGE: begin
                    if (btn_fall) begin
                        state       <= FLY;
                        dir_up      <= turn;
                        pos         <= src_col;
                        shoot_valid <= src_valid;
                        tgt_col     <= dst_col;
                        tgt_valid   <= dst_valid;
                        shell_col   <= src_valid ? (8'd1 << src_col) : '0;
                        step        <= '0;
                        tick        <= '0;
                    end else if (tick_done) begin
                        tick <= '0;
                        if (power != 3'd7) begin
                            power <= power + 3'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                FLY: begin
                    // The final move and the landing share one edge, so the result
                    // appears exactly power*TICK_DIV cycles after FLY entry.
                    if (!shoot_valid || power == 3'd0) begin
                        hit       <= 1'b0;
                        fire      <= 1'b0;
                        shell_col <= '0;
                        state     <= IDLE;
                    end else if (tick_done) begin
                        tick <= '0;
                        if (edge_exit) begin
                            hit       <= 1'b0;
                            fire      <= 1'b0;
                            shell_col <= '0;
                            state     <= IDLE;
                        end else if (step + 3'd1 == power) begin
                            hit       <= tgt_valid && (pos_next == tgt_col);
                            fire      <= 1'b0;
                            shell_col <= '0;
                            state     <= IDLE;
                        end else begin
                            pos       <= pos_next;
                            shell_col <= 8'd1 << pos_next;
                            step      <= step + 3'd1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    fire      <= 1'b0;
                    shell_col <= '0;
                end
            endcase
        end
    end

    assign busy = fire;

endmodule
